dht22_temp_bcd: RTL
===================

DHT22_TEMP_BCD -- requirements
Module: dht22_temp_bcd

Interface
REQ-001 The block SHALL have parameter MAX_TEMP, default 1250, giving the largest accepted magnitude in 0.1 degC units; the legal range is 0..1999.
REQ-002 The block SHALL have port clk, input, 1 bit: the system clock, the only clock in the block.
REQ-003 The block SHALL have port res, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port temp_in, input, 16 bits: DHT22 temperature word; bit 15 is the sign, bits 14:0 are magnitude in 0.1 degC.
REQ-005 The block SHALL have port sign, output, 1 bit: 1 when the displayed value is negative.
REQ-006 The block SHALL have port bcd_hun, output, 4 bits: hundreds digit, always 0 or 1.
REQ-007 The block SHALL have ports bcd_ten, bcd_one and bcd_tenth, outputs, 4 bits each: tens, ones and tenths digits.
REQ-008 The block SHALL have port over_range, output, 1 bit: the last accepted magnitude exceeded MAX_TEMP.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: a one-cycle pulse when the outputs update.

Function
REQ-011 temp_in SHALL be registered every clk edge into temp_q.
REQ-012 The FSM SHALL have three states: IDLE, CONV and DONE.
REQ-013 IDLE: accept a word on the first edge where temp_in == temp_q and temp_q != last_temp; on that edge latch last_temp <= temp_q, load the shifter, clear iter_cnt and go to CONV.
REQ-014 The magnitude SHALL be bits 14:0 of the accepted word; out_range = (magnitude > MAX_TEMP), evaluated on the acceptance edge.
REQ-015 When out_range is 0, the shifter SHALL be loaded with magnitude[10:0] and a zeroed 16-bit BCD field.
REQ-016 CONV: on each edge, any BCD nibble >= 5 SHALL have 3 added, then {bcd, bin} SHALL shift left by 1 and iter_cnt SHALL increment.
REQ-017 CONV SHALL exit to DONE after exactly 11 shift edges.
REQ-018 DONE, one edge: update the outputs, pulse done for that cycle, then go to IDLE.
REQ-019 Latency: done SHALL be high in the cycle following the 12th rising edge after the acceptance edge.
REQ-020 In-range update: bcd_* <= conversion result; sign <= bit 15 AND (magnitude != 0), so 0x8000 displays +0; over_range <= 0.
REQ-021 Out-of-range update: over_range <= 1; sign and all bcd_* SHALL hold their previous values; done SHALL still pulse with the same latency.
REQ-022 Out-of-range acceptance SHALL still pass through CONV for 11 edges so that latency is data-independent.
REQ-023 busy SHALL be 1 in CONV and DONE, and 0 in IDLE.
REQ-024 Changes of temp_in during CONV or DONE SHALL NOT affect the conversion in progress.
REQ-025 A value still differing from last_temp on return to IDLE SHALL be accepted by the normal IDLE rule.
REQ-026 A single-cycle glitch on temp_in (temp_in != temp_q) SHALL never be accepted.
REQ-027 Re-presenting the same word as last_temp SHALL start no conversion and SHALL produce no done pulse.

Reset
REQ-028 res low SHALL immediately force: state IDLE, temp_q = 0, last_temp = 0, iter_cnt = 0, shifter = 0, sign = 0, all bcd_* = 0, over_range = 0, busy = 0, done = 0.
REQ-029 Reset asserted mid-conversion SHALL abort the conversion with no done pulse; after release, the held temp_in SHALL be re-accepted if nonzero.
REQ-030 Because last_temp resets to 0, temp_in = 0x0000 after reset SHALL produce no conversion; the outputs already show +000.0.

Verification
REQ-031 temp_in 0x00FB held -> sign 0, bcd 0/2/5/1, over_range 0, one done pulse at the REQ-019 latency, busy high throughout.
REQ-032 temp_in 0x8065 -> sign 1, bcd 0/1/0/1.
REQ-033 0x04E2 -> bcd 1/2/5/0, over_range 0; then 0x04E3 -> over_range 1, bcd remains 1/2/5/0, done pulses.
REQ-034 0x8000 after a nonzero value -> sign 0, bcd 0/0/0/0.
REQ-035 0x00FB accepted, then 0x0101 applied on the 5th CONV edge -> first done reports 0/2/5/1, second done reports 0/2/5/7; a one-cycle glitch to 0x0FFF in IDLE -> no conversion.
REQ-036 res pulsed low on the 6th CONV edge -> all outputs 0 immediately, no done; after release with temp_in 0x00FB held -> normal conversion to 0/2/5/1.

Source files
------------

// File: rtl/dht22_temp_bcd.sv
// DHT22 temperature word to signed 4-digit BCD display value (0.1 degC resolution).
// A new word is accepted only after it has been stable for two edges; the conversion is double-dabble.
module dht22_temp_bcd #(
  parameter int unsigned MAX_TEMP = 1250
) (
  input  logic        clk,
  input  logic        res,
  input  logic [15:0] temp_in,
  output logic        sign,
  output logic [3:0]  bcd_hun,
  output logic [3:0]  bcd_ten,
  output logic [3:0]  bcd_one,
  output logic [3:0]  bcd_tenth,
  output logic        over_range,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  localparam logic [14:0] MAX_MAG   = 15'(MAX_TEMP);
  localparam logic [3:0]  LAST_ITER = 4'd10;
  localparam int unsigned BIN_W     = 11;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] temp_q;
  logic [15:0] last_temp;
  logic [3:0]  iter_cnt;
  logic [26:0] shifter;
  logic [26:0] shift_adj;
  logic        out_range;
  logic        accept;
  logic [14:0] mag_in;

  assign mag_in = temp_q[14:0];
  assign accept = (temp_in == temp_q) && (temp_q != last_temp);

  // Add-3 correction on each BCD nibble before the shift.
  always_comb begin
    shift_adj = shifter;
    for (int unsigned i = 0; i < 4; i++) begin
      if (shifter[BIN_W + 4*i +: 4] >= 4'd5)
        shift_adj[BIN_W + 4*i +: 4] = shifter[BIN_W + 4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CONV;
      CONV:    if (iter_cnt == LAST_ITER) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      temp_q     <= '0;
      last_temp  <= '0;
      iter_cnt   <= '0;
      shifter    <= '0;
      out_range  <= 1'b0;
      sign       <= 1'b0;
      bcd_hun    <= '0;
      bcd_ten    <= '0;
      bcd_one    <= '0;
      bcd_tenth  <= '0;
      over_range <= 1'b0;
      done       <= 1'b0;
    end else begin
      temp_q <= temp_in;
      done   <= (state == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            last_temp <= temp_q;
            out_range <= (mag_in > MAX_MAG);
            iter_cnt  <= '0;
            // Out-of-range words still run the full shift sequence to keep latency fixed.
            shifter   <= (mag_in > MAX_MAG) ? '0 : {16'h0000, mag_in[BIN_W-1:0]};
          end
        end
        CONV: begin
          shifter  <= shift_adj << 1;
          iter_cnt <= iter_cnt + 4'd1;
        end
        DONE: begin
          if (out_range) begin
            over_range <= 1'b1;
          end else begin
            over_range <= 1'b0;
            sign       <= last_temp[15] & (|last_temp[14:0]);
            bcd_hun    <= shifter[26:23];
            bcd_ten    <= shifter[22:19];
            bcd_one    <= shifter[18:15];
            bcd_tenth  <= shifter[14:11];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
